// File: rtl/minimig_sram_arbiter.sv
// Shares the SRAM bridge between the chipset (absolute priority, zero added latency) and a host
// req/ack port; one arbitration per bus cycle at Q0, the host only gets slots the chipset leaves idle.
module minimig_sram_arbiter #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        c1,
  input  logic        c3,
  input  logic [7:0]  chip_bank,
  input  logic [22:0] chip_address,
  input  logic [15:0] chip_data_in,
  input  logic        chip_rd,
  input  logic        chip_hwr,
  input  logic        chip_lwr,
  output logic [15:0] chip_data_out,
  input  logic        host_req,
  input  logic [7:0]  host_bank,
  input  logic [22:0] host_address,
  input  logic [15:0] host_wdata,
  input  logic        host_we,
  input  logic [1:0]  host_be,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_starved,
  output logic [7:0]  br_bank,
  output logic [22:0] br_address,
  output logic [15:0] br_data_in,
  output logic        br_rd,
  output logic        br_hwr,
  output logic        br_lwr,
  input  logic [15:0] br_data_out
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CHIP, OWN_HOST} owner_t;
  typedef enum logic [1:0] {H_IDLE, H_PEND, H_ACTIVE, H_DONE} hstate_t;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  owner_t            owner;
  hstate_t           state_q, state_d;
  logic              ack_set, ack_clr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        sh_bank;
  logic [22:0]       sh_address;
  logic [15:0]       sh_wdata;
  logic              sh_we;
  logic [1:0]        sh_be;

  logic q0, q1, q2, q3, chip_req, grant;
  assign q0 = !c1 && !c3;
  assign q1 =  c1 && !c3;
  assign q2 =  c1 &&  c3;
  assign q3 = !c1 &&  c3;

  assign chip_req = |chip_bank;
  // A request withdrawn while pending is treated as void, so it can never be granted.
  assign grant    = q0 && !chip_req && (state_q == H_PEND) && host_req;

  assign host_starved = (wait_cnt == MAX_CNT);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      owner      <= OWN_NONE;
      state_q    <= H_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      wait_cnt   <= '0;
      sh_bank    <= '0;
      sh_address <= '0;
      sh_wdata   <= '0;
      sh_we      <= 1'b0;
      sh_be      <= '0;
    end else begin
      state_q <= state_d;
      if (q0) owner <= chip_req ? OWN_CHIP : (grant ? OWN_HOST : OWN_NONE);
      if (grant) begin
        sh_bank    <= host_bank;
        sh_address <= host_address;
        sh_wdata   <= host_wdata;
        sh_we      <= host_we;
        sh_be      <= host_be;
      end
      if (ack_set) begin
        host_ack <= 1'b1;
        if (!sh_we) host_rdata <= br_data_out;
      end else if (ack_clr) begin
        host_ack <= 1'b0;
      end
      if (state_q == H_IDLE || grant)
        wait_cnt <= '0;
      else if (q0 && state_q == H_PEND && host_req && chip_req && wait_cnt != MAX_CNT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_set = 1'b0;
    ack_clr = 1'b0;
    case (state_q)
      H_IDLE:   if (host_req) state_d = H_PEND;
      H_PEND:   if (!host_req) state_d = H_IDLE;
                else if (grant) state_d = H_ACTIVE;
      H_ACTIVE: if (q3) begin
                  state_d = H_DONE;
                  ack_set = 1'b1;
                end
      H_DONE:   if (!host_req) begin
                  state_d = H_IDLE;
                  ack_clr = 1'b1;
                end
      default:  state_d = H_IDLE;
    endcase
  end

  // Host strobes drop in Q3 so address/data hold past the write edge; bank is released in the trailing Q0.
  always_comb begin
    br_bank       = '0;
    br_address    = '0;
    br_data_in    = '0;
    br_rd         = 1'b0;
    br_hwr        = 1'b0;
    br_lwr        = 1'b0;
    chip_data_out = '0;
    case (owner)
      OWN_CHIP: begin
        br_bank       = chip_bank;
        br_address    = chip_address;
        br_data_in    = chip_data_in;
        br_rd         = chip_rd;
        br_hwr        = chip_hwr;
        br_lwr        = chip_lwr;
        chip_data_out = br_data_out;
      end
      OWN_HOST: begin
        br_bank    = q0 ? 8'h00 : sh_bank;
        br_address = sh_address;
        br_data_in = sh_wdata;
        br_rd      = !sh_we && !q0;
        br_hwr     = sh_we && sh_be[1] && (q1 || q2);
        br_lwr     = sh_we && sh_be[0] && (q1 || q2);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Directed bench for minimig_sram_arbiter with a 4-clock c1/c3 phase generator (MAX_WAIT=4).
module tb_minimig_sram_arbiter;

  logic        clk = 1'b0;
  logic        _reset;
  logic        c1, c3;
  logic [7:0]  chip_bank;
  logic [22:0] chip_address;
  logic [15:0] chip_data_in;
  logic        chip_rd, chip_hwr, chip_lwr;
  logic [15:0] chip_data_out;
  logic        host_req;
  logic [7:0]  host_bank;
  logic [22:0] host_address;
  logic [15:0] host_wdata;
  logic        host_we;
  logic [1:0]  host_be;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_starved;
  logic [7:0]  br_bank;
  logic [22:0] br_address;
  logic [15:0] br_data_in;
  logic        br_rd, br_hwr, br_lwr;
  logic [15:0] br_data_out;

  logic [1:0]  ph = 2'd0;
  int          n_checks = 0;
  int          n_err = 0;
  int          extra;
  int          got_ack;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign c1 = (ph == 2'd1) || (ph == 2'd2);
  assign c3 = (ph == 2'd2) || (ph == 2'd3);

  minimig_sram_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk(clk), ._reset(_reset), .c1(c1), .c3(c3),
    .chip_bank(chip_bank), .chip_address(chip_address), .chip_data_in(chip_data_in),
    .chip_rd(chip_rd), .chip_hwr(chip_hwr), .chip_lwr(chip_lwr), .chip_data_out(chip_data_out),
    .host_req(host_req), .host_bank(host_bank), .host_address(host_address),
    .host_wdata(host_wdata), .host_we(host_we), .host_be(host_be),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_starved(host_starved),
    .br_bank(br_bank), .br_address(br_address), .br_data_in(br_data_in),
    .br_rd(br_rd), .br_hwr(br_hwr), .br_lwr(br_lwr), .br_data_out(br_data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ph(input logic [1:0] p);
    do @(negedge clk); while (ph != p);
  endtask

  task automatic host_cmd(input logic we, input logic [1:0] be, input logic [7:0] bank,
                          input logic [22:0] addr, input logic [15:0] wd);
    host_we = we; host_be = be; host_bank = bank; host_address = addr; host_wdata = wd;
    host_req = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    _reset = 1'b0;
    chip_bank = '0; chip_address = '0; chip_data_in = '0;
    chip_rd = 1'b0; chip_hwr = 1'b0; chip_lwr = 1'b0;
    host_req = 1'b0; host_bank = '0; host_address = '0; host_wdata = '0;
    host_we = 1'b0; host_be = '0; br_data_out = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", host_ack, 0);
    check("rst_bank", br_bank, 0);
    check("rst_rdata", host_rdata, 0);
    check("rst_starved", host_starved, 0);
    check("rst_rd", br_rd, 0);
    _reset = 1'b1;

    // Chipset read mirrors straight through
    wait_ph(0);
    chip_bank = 8'h01; chip_address = 23'h000100; chip_rd = 1'b1; br_data_out = 16'hA55A;
    wait_ph(1);
    check("chip_bank", br_bank, 8'h01);
    check("chip_addr", br_address, 23'h000100);
    check("chip_rd", br_rd, 1);
    check("chip_dout", chip_data_out, 16'hA55A);
    wait_ph(3);
    check("chip_rd_q3", br_rd, 1);
    check("chip_noack", host_ack, 0);
    wait_ph(0);
    chip_bank = '0; chip_rd = 1'b0; chip_address = '0;
    wait_ph(1);
    check("idle_bank", br_bank, 0);
    check("idle_dout", chip_data_out, 0);

    // Host write, chipset idle
    host_cmd(1'b1, 2'b01, 8'h04, 23'h040000, 16'h1234);
    wait_ph(1);
    check("hw_lwr_q1", br_lwr, 1);
    check("hw_hwr_q1", br_hwr, 0);
    check("hw_bank", br_bank, 8'h04);
    check("hw_addr", br_address, 23'h040000);
    check("hw_data", br_data_in, 16'h1234);
    check("hw_rd", br_rd, 0);
    wait_ph(2);
    check("hw_lwr_q2", br_lwr, 1);
    host_wdata = 16'h0000;
    wait_ph(3);
    check("hw_lwr_q3", br_lwr, 0);
    check("hw_data_q3", br_data_in, 16'h1234);
    check("hw_ack_q3", host_ack, 0);
    wait_ph(0);
    check("hw_ack", host_ack, 1);
    check("hw_bank_q0", br_bank, 0);
    repeat (6) @(negedge clk);
    check("hw_ack_hold", host_ack, 1);
    host_req = 1'b0;
    @(negedge clk);
    check("hw_ack_drop", host_ack, 0);

    // Host read held off by three busy chipset slots
    wait_ph(1);
    host_cmd(1'b0, 2'b11, 8'h02, 23'h012345, 16'h0000);
    chip_bank = 8'h01; chip_rd = 1'b1; chip_address = 23'h000200; br_data_out = 16'h1111;
    for (int i = 0; i < 3; i++) wait_ph(1);
    check("hr_cnt3", dut.wait_cnt, 3);
    check("hr_starved", host_starved, 0);
    check("hr_chipbank", br_bank, 8'h01);
    check("hr_noack", host_ack, 0);
    chip_bank = '0; chip_rd = 1'b0; br_data_out = 16'hBEEF;
    wait_ph(1);
    check("hr_rd", br_rd, 1);
    check("hr_bank", br_bank, 8'h02);
    check("hr_addr", br_address, 23'h012345);
    check("hr_cnt_clr", dut.wait_cnt, 0);
    check("hr_chip_dout", chip_data_out, 0);
    wait_ph(0);
    check("hr_ack", host_ack, 1);
    check("hr_rdata", host_rdata, 16'hBEEF);
    host_req = 1'b0;
    @(negedge clk);

    // Starvation threshold with six denied slots
    wait_ph(1);
    host_cmd(1'b1, 2'b10, 8'h08, 23'h7FFFFF, 16'h5A5A);
    chip_bank = 8'h80; chip_hwr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_ph(1);
      check($sformatf("starved_%0d", i), host_starved, (i >= 4) ? 1 : 0);
    end
    check("starve_sat", dut.wait_cnt, 4);
    chip_bank = '0; chip_hwr = 1'b0;
    wait_ph(1);
    check("starve_clr", host_starved, 0);
    check("st_hwr", br_hwr, 1);
    check("st_lwr", br_lwr, 0);
    check("st_bank", br_bank, 8'h08);
    wait_ph(0);
    check("st_ack", host_ack, 1);

    // Request held after ack: no second access
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (br_bank != 0 || br_hwr || br_lwr || br_rd || !host_ack) extra++;
    end
    check("held_single", extra, 0);
    host_req = 1'b0;
    @(negedge clk);
    check("held_ackdrop", host_ack, 0);
    host_cmd(1'b1, 2'b11, 8'h01, 23'h000010, 16'h0F0F);
    got_ack = 0;
    for (int i = 0; i < 20 && got_ack == 0; i++) begin
      @(negedge clk);
      if (host_ack) got_ack = 1;
    end
    check("rereq_ack", got_ack, 1);
    host_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in Q2 of a host write
    wait_ph(1);
    host_cmd(1'b1, 2'b11, 8'h01, 23'h000020, 16'hABCD);
    wait_ph(1);
    wait_ph(2);
    check("mr_hwr_pre", br_hwr, 1);
    _reset = 1'b0;
    host_req = 1'b0;
    #1;
    check("mr_hwr", br_hwr, 0);
    check("mr_lwr", br_lwr, 0);
    check("mr_bank", br_bank, 0);
    check("mr_ack", host_ack, 0);
    @(negedge clk);
    _reset = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (br_bank != 0 || br_hwr || br_lwr || host_ack) extra++;
    end
    check("mr_noaccess", extra, 0);
    wait_ph(0);
    chip_bank = 8'h02; chip_lwr = 1'b1;
    wait_ph(1);
    check("mr_chip_bank", br_bank, 8'h02);
    check("mr_chip_lwr", br_lwr, 1);
    chip_bank = '0; chip_lwr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
